// File: rtl/scr_pkg.sv
// Shared types and constants for the scrambler frame sequencer.
package scr_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSync    = 2'd1,
    StPayload = 2'd2
  } state_e;

  // Per-bit tag that travels alongside the scrambler latency.
  typedef struct packed {
    logic valid;
    logic sel;
    logic sync_bit;
    logic sof;
  } tag_t;

  localparam logic [15:0] SyncWordDefault = 16'hF628;
  localparam logic [7:0]  FillWordDefault = 8'h00;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scr_align_pipe.sv
// Tag delay line matching the external scrambler latency; DEPTH = 0 is a wire.
module scr_align_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = ^{clk, rst};
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign dout = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/scrambler_frame_ctrl.sv
// Frame sequencer: unscrambled sync word, then FRAME_LEN payload words serialized
// MSB-first through an external scrambler that is reseeded before every payload.
module scrambler_frame_ctrl
  import scr_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       FRAME_LEN = 4,
  parameter int unsigned       SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SyncWordDefault),
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FillWordDefault),
  parameter int unsigned       SCR_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              scr_rst,
  output logic              scr_bit_in,
  input  logic              scr_bit_out,
  output logic              line_bit,
  output logic              line_valid,
  output logic              line_sof,
  output logic              underrun,
  output logic              busy
);

  localparam int unsigned BitMax = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned BitW   = cnt_w(BitMax);
  localparam int unsigned WordW  = cnt_w(FRAME_LEN);

  localparam logic [BitW-1:0]  SyncLast = BitW'(SYNC_W - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_W - 1);
  localparam logic [WordW-1:0] WordLast = WordW'(FRAME_LEN - 1);

  state_e             state_q, state_d;
  logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WordW-1:0]   word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [BitW-1:0]    sync_idx;
  logic               load;
  tag_t               tag_in, tag_out;
  logic               line_bit_q, line_valid_q, line_sof_q;

  assign sync_idx = SyncLast - bit_cnt_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shreg_d    = shreg_q;
    load       = 1'b0;
    scr_rst    = 1'b1;
    scr_bit_in = 1'b0;
    tag_in     = '0;

    unique case (state_q)
      StIdle: begin
        if (en && s_valid) begin
          state_d   = StSync;
          bit_cnt_d = '0;
        end
      end
      StSync: begin
        tag_in.valid    = 1'b1;
        tag_in.sync_bit = SYNC_WORD[sync_idx];
        tag_in.sof      = (bit_cnt_q == '0);
        if (bit_cnt_q == SyncLast) begin
          load       = 1'b1;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = StPayload;
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      StPayload: begin
        scr_rst    = 1'b0;
        scr_bit_in = shreg_q[DATA_W-1];
        tag_in.valid = 1'b1;
        tag_in.sel   = 1'b1;
        shreg_d      = shreg_q << 1;
        if (bit_cnt_q == DataLast) begin
          bit_cnt_d = '0;
          if (word_cnt_q == WordLast) begin
            word_cnt_d = '0;
            state_d    = (en && s_valid) ? StSync : StIdle;
          end else begin
            load       = 1'b1;
            word_cnt_d = word_cnt_q + WordW'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A frame never stalls: a missing word is replaced by the fill pattern.
    if (load) shreg_d = s_valid ? s_data : FILL_WORD;
  end

  assign s_ready  = load & ~rst;
  assign underrun = load & ~s_valid & ~rst;
  assign busy     = (state_q != StIdle);

  scr_align_pipe #(
    .DEPTH (SCR_LAT),
    .WIDTH ($bits(tag_t))
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      line_bit_q   <= 1'b0;
      line_valid_q <= 1'b0;
      line_sof_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
      line_bit_q   <= tag_out.sel ? scr_bit_out : tag_out.sync_bit;
      line_valid_q <= tag_out.valid;
      line_sof_q   <= tag_out.sof;
    end
  end

  assign line_bit   = line_bit_q;
  assign line_valid = line_valid_q;
  assign line_sof   = line_sof_q;

endmodule

// File: tb/tb_scrambler_frame_ctrl.sv
// Directed bench: a SCR_LAT=1 instance with an additive LFSR scrambler model, plus
// SCR_LAT=0 and SCR_LAT=2 instances fed by identity scramblers for alignment checks.
module tb_scrambler_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;

  logic s_ready, scr_rst, scr_bit_in, scr_bit_out, line_bit, line_valid, line_sof;
  logic underrun, busy;
  logic s_ready_l0, scr_rst_l0, scr_bit_in_l0, scr_bit_out_l0, line_bit_l0, line_valid_l0;
  logic line_sof_l0, underrun_l0, busy_l0;
  logic s_ready_l2, scr_rst_l2, scr_bit_in_l2, scr_bit_out_l2, line_bit_l2, line_valid_l2;
  logic line_sof_l2, underrun_l2, busy_l2;

  scrambler_frame_ctrl #(.SCR_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .scr_rst(scr_rst), .scr_bit_in(scr_bit_in), .scr_bit_out(scr_bit_out),
    .line_bit(line_bit), .line_valid(line_valid), .line_sof(line_sof),
    .underrun(underrun), .busy(busy)
  );

  scrambler_frame_ctrl #(.SCR_LAT(0)) dut_l0 (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l0),
    .scr_rst(scr_rst_l0), .scr_bit_in(scr_bit_in_l0), .scr_bit_out(scr_bit_out_l0),
    .line_bit(line_bit_l0), .line_valid(line_valid_l0), .line_sof(line_sof_l0),
    .underrun(underrun_l0), .busy(busy_l0)
  );

  scrambler_frame_ctrl #(.SCR_LAT(2)) dut_l2 (
    .clk(clk), .rst(rst), .en(en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_l2),
    .scr_rst(scr_rst_l2), .scr_bit_in(scr_bit_in_l2), .scr_bit_out(scr_bit_out_l2),
    .line_bit(line_bit_l2), .line_valid(line_valid_l2), .line_sof(line_sof_l2),
    .underrun(underrun_l2), .busy(busy_l2)
  );

  // Additive scrambler x^7 + x^6 + 1, seed 7'h7F, one cycle latency.
  logic [6:0] lfsr = 7'h7F;
  logic       scr_q = 1'b0;
  always @(posedge clk) begin
    if (scr_rst) begin
      lfsr  <= 7'h7F;
      scr_q <= 1'b0;
    end else begin
      scr_q <= scr_bit_in ^ lfsr[6];
      lfsr  <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end
  assign scr_bit_out = scr_q;

  assign scr_bit_out_l0 = scr_bit_in_l0;
  logic d2a = 1'b0, d2b = 1'b0;
  always @(posedge clk) begin
    d2a <= scr_bit_in_l2;
    d2b <= d2a;
  end
  assign scr_bit_out_l2 = d2b;

  int vectors = 0;
  int miscompares = 0;

  // Word source: tasks publish a window (base, len, words); this process presents it.
  logic [7:0] src_words [16];
  int src_base = 0, src_len = 0;
  int cons_cnt = 0, ready_cnt = 0, under_cnt = 0, sync_rst_cnt = 0;
  always begin
    @(negedge clk);
    if (cons_cnt - src_base < src_len) begin
      s_valid = 1'b1;
      s_data  = src_words[cons_cnt - src_base];
    end else begin
      s_valid = 1'b0;
      s_data  = 8'h00;
    end
    #3;
    if (s_ready) ready_cnt++;
    if (s_valid && s_ready) cons_cnt++;
    if (underrun) under_cnt++;
    if (busy && scr_rst) sync_rst_cnt++;
  end

  logic line_q [$];
  int   runs [$];
  int   sof_idx [$];
  int   run_len = 0;
  always @(negedge clk) begin
    if (line_valid) begin
      if (line_sof) sof_idx.push_back(line_q.size());
      line_q.push_back(line_bit);
      run_len++;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
  end

  function automatic logic key_bit(input int j);
    logic [6:0] l = 7'h7F;
    for (int i = 0; i < j; i++) l = {l[5:0], l[6] ^ l[5]};
    return l[6];
  endfunction

  function automatic logic line_at(input int idx);
    return (idx < line_q.size()) ? line_q[idx] : 1'b0;
  endfunction

  function automatic logic [15:0] sync_at(input int base);
    logic [15:0] s = '0;
    for (int j = 0; j < 16; j++) s = {s[14:0], line_at(base + j)};
    return s;
  endfunction

  function automatic logic [31:0] decode_payload(input int base);
    logic [31:0] w = '0;
    for (int j = 0; j < 32; j++) w = {w[30:0], line_at(base + j) ^ key_bit(j)};
    return w;
  endfunction

  task automatic wait_frame_done(output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    int r0;
    rst = 1'b1;
    en  = 1'b0;
    src_base = cons_cnt;
    src_len  = 0;
    r0 = ready_cnt;
    repeat (3) @(negedge clk);
    vectors++;
    if (scr_rst !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_scr_rst: got %b want 1", scr_rst);
    end
    vectors++;
    if ({line_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valid_busy: got %b want 00", {line_valid, busy});
    end
    vectors++;
    if ({line_bit, line_sof, underrun, s_ready, scr_bit_in} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 00000",
               {line_bit, line_sof, underrun, s_ready, scr_bit_in});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if ({busy, scr_rst, line_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b want 010", {busy, scr_rst, line_valid});
    end
    vectors++;
    if (ready_cnt - r0 != 0) begin
      miscompares++;
      $display("FAIL reset_s_ready: got %0d pulses want 0", ready_cnt - r0);
    end
  endtask

  task automatic test_single_frame();
    int q0, n0, s0, r0, u0, rl, sp;
    bit ok;
    q0 = line_q.size(); n0 = runs.size(); s0 = sof_idx.size();
    r0 = ready_cnt; u0 = under_cnt;
    src_words[0] = 8'hA5; src_words[1] = 8'h3C; src_words[2] = 8'hFF; src_words[3] = 8'h01;
    src_base = cons_cnt;
    src_len  = 4;
    en = 1'b1;
    wait_frame_done(ok);
    en = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_done: got timeout want frame end");
    end
    rl = (runs.size() == n0 + 1) ? runs[n0] : -1;
    vectors++;
    if (rl != 48) begin
      miscompares++;
      $display("FAIL single_len: got %0d want 48", rl);
    end
    sp = (sof_idx.size() == s0 + 1) ? sof_idx[s0] - q0 : -1;
    vectors++;
    if (sp != 0) begin
      miscompares++;
      $display("FAIL single_sof: got offset %0d want 0 (single pulse)", sp);
    end
    vectors++;
    if (sync_at(q0) !== 16'hF628) begin
      miscompares++;
      $display("FAIL single_sync: got %h want f628", sync_at(q0));
    end
    vectors++;
    if (decode_payload(q0 + 16) !== 32'hA53CFF01) begin
      miscompares++;
      $display("FAIL single_payload: got %h want a53cff01", decode_payload(q0 + 16));
    end
    vectors++;
    if (ready_cnt - r0 != 4 || under_cnt - u0 != 0) begin
      miscompares++;
      $display("FAIL single_handshake: got ready %0d under %0d want 4 0",
               ready_cnt - r0, under_cnt - u0);
    end
  endtask

  task automatic test_underrun();
    int q0, n0, r0, u0, rl;
    bit ok, seen, fed;
    q0 = line_q.size(); n0 = runs.size(); r0 = ready_cnt; u0 = under_cnt;
    src_words[0] = 8'hA5; src_words[1] = 8'h3C; src_words[2] = 8'h01;
    src_base = cons_cnt;
    src_len  = 2;
    en = 1'b1;
    ok = 1'b0; seen = 1'b0; fed = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!fed && under_cnt != u0) begin
        src_len = 3;
        fed = 1'b1;
      end
      if (busy) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk);
    en = 1'b0;
    vectors++;
    if (!ok || under_cnt - u0 != 1) begin
      miscompares++;
      $display("FAIL underrun_pulse: got %0d pulses (done=%0d) want 1", under_cnt - u0, ok);
    end
    rl = (runs.size() == n0 + 1) ? runs[n0] : -1;
    vectors++;
    if (rl != 48) begin
      miscompares++;
      $display("FAIL underrun_len: got %0d want 48", rl);
    end
    vectors++;
    if (decode_payload(q0 + 16) !== 32'hA53C0001) begin
      miscompares++;
      $display("FAIL underrun_payload: got %h want a53c0001", decode_payload(q0 + 16));
    end
    vectors++;
    if (ready_cnt - r0 != 4) begin
      miscompares++;
      $display("FAIL underrun_ready: got %0d want 4", ready_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int q0, n0, s0, r0, c0, rl, sp;
    bit ok;
    logic [63:0] words = 64'h123456789ABCDEF0;
    q0 = line_q.size(); n0 = runs.size(); s0 = sof_idx.size();
    r0 = ready_cnt; c0 = sync_rst_cnt;
    for (int i = 0; i < 8; i++) src_words[i] = words[63 - 8*i -: 8];
    src_base = cons_cnt;
    src_len  = 8;
    en = 1'b1;
    wait_frame_done(ok);
    en = 1'b0;
    rl = (runs.size() == n0 + 1) ? runs[n0] : -1;
    vectors++;
    if (!ok || rl != 96) begin
      miscompares++;
      $display("FAIL b2b_len: got %0d (done=%0d) want 96", rl, ok);
    end
    sp = (sof_idx.size() == s0 + 2) ? sof_idx[s0 + 1] - q0 : -1;
    vectors++;
    if (sp != 48) begin
      miscompares++;
      $display("FAIL b2b_sof2: got offset %0d want 48", sp);
    end
    vectors++;
    if ({sync_at(q0), sync_at(q0 + 48)} !== 32'hF628F628) begin
      miscompares++;
      $display("FAIL b2b_sync: got %h %h want f628 f628", sync_at(q0), sync_at(q0 + 48));
    end
    vectors++;
    if (decode_payload(q0 + 16) !== 32'h12345678) begin
      miscompares++;
      $display("FAIL b2b_payload1: got %h want 12345678", decode_payload(q0 + 16));
    end
    vectors++;
    if (decode_payload(q0 + 64) !== 32'h9ABCDEF0) begin
      miscompares++;
      $display("FAIL b2b_payload2: got %h want 9abcdef0", decode_payload(q0 + 64));
    end
    vectors++;
    if (sync_rst_cnt - c0 != 32 || ready_cnt - r0 != 8) begin
      miscompares++;
      $display("FAIL b2b_counts: got scr_rst %0d ready %0d want 32 8",
               sync_rst_cnt - c0, ready_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_payload();
    int q0, n0, rl;
    bit ok, found;
    src_words[0] = 8'h11; src_words[1] = 8'h22; src_words[2] = 8'h33; src_words[3] = 8'h44;
    src_base = cons_cnt;
    src_len  = 4;
    en = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy && !scr_rst) begin
        found = 1'b1;
        break;
      end
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    vectors++;
    if (!found || {line_valid, busy, scr_rst} !== 3'b001) begin
      miscompares++;
      $display("FAIL midrst_state: got valid/busy/scr_rst %b (payload=%0d) want 001",
               {line_valid, busy, scr_rst}, found);
    end
    rst = 1'b0;
    @(negedge clk);
    q0 = line_q.size(); n0 = runs.size();
    src_words[0] = 8'h5A; src_words[1] = 8'hC3; src_words[2] = 8'h0F; src_words[3] = 8'hF0;
    src_base = cons_cnt;
    src_len  = 4;
    en = 1'b1;
    wait_frame_done(ok);
    en = 1'b0;
    rl = (runs.size() == n0 + 1) ? runs[n0] : -1;
    vectors++;
    if (!ok || rl != 48) begin
      miscompares++;
      $display("FAIL midrst_len: got %0d (done=%0d) want 48", rl, ok);
    end
    vectors++;
    if (sync_at(q0) !== 16'hF628) begin
      miscompares++;
      $display("FAIL midrst_sync: got %h want f628", sync_at(q0));
    end
    vectors++;
    if (decode_payload(q0 + 16) !== 32'h5AC30FF0) begin
      miscompares++;
      $display("FAIL midrst_payload: got %h want 5ac30ff0", decode_payload(q0 + 16));
    end
  endtask

  task automatic test_en_latency();
    int sof_c [3];
    int last_v [3];
    int vcnt [3];
    logic [47:0] vec [3];
    logic [47:0] exp_vec;
    logic [2:0] lv, ls, lb;
    int last_busy;
    exp_vec = {16'hF628, 32'h817E55AA};
    for (int i = 0; i < 3; i++) begin
      sof_c[i] = -1; last_v[i] = -1; vcnt[i] = 0; vec[i] = '0;
    end
    last_busy = -1;
    src_words[0] = 8'h81; src_words[1] = 8'h7E; src_words[2] = 8'h55; src_words[3] = 8'hAA;
    src_base = cons_cnt;
    src_len  = 4;
    en = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if ({busy, busy_l0, busy_l2, line_valid, line_valid_l0, line_valid_l2} !== 6'b0) begin
      miscompares++;
      $display("FAIL en_gate: got busy/valid %b want 000000",
               {busy, busy_l0, busy_l2, line_valid, line_valid_l0, line_valid_l2});
    end
    en = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vectors++;
        if ({busy, busy_l0, busy_l2} !== 3'b111) begin
          miscompares++;
          $display("FAIL en_start: got busy %b want 111", {busy, busy_l0, busy_l2});
        end
      end
      if (busy) last_busy = c;
      lv = {line_valid_l2, line_valid, line_valid_l0};
      ls = {line_sof_l2, line_sof, line_sof_l0};
      lb = {line_bit_l2, line_bit, line_bit_l0};
      for (int i = 0; i < 3; i++) begin
        if (ls[i] && sof_c[i] < 0) sof_c[i] = c;
        if (lv[i]) begin
          vcnt[i]++;
          vec[i] = {vec[i][46:0], lb[i]};
          last_v[i] = c;
        end
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sof_c[i] != 2 + i) begin
        miscompares++;
        $display("FAIL lat%0d_sof: got cycle %0d want %0d", i, sof_c[i], 2 + i);
      end
      vectors++;
      if (last_v[i] - last_busy != i + 1) begin
        miscompares++;
        $display("FAIL lat%0d_drain: got %0d want %0d", i, last_v[i] - last_busy, i + 1);
      end
      vectors++;
      if (vcnt[i] != 48) begin
        miscompares++;
        $display("FAIL lat%0d_len: got %0d want 48", i, vcnt[i]);
      end
    end
    vectors++;
    if (vec[0] !== exp_vec || vec[2] !== exp_vec) begin
      miscompares++;
      $display("FAIL lat_bits: got %h %h want %h", vec[0], vec[2], exp_vec);
    end
    vectors++;
    if (vec[1][47:32] !== 16'hF628) begin
      miscompares++;
      $display("FAIL lat1_sync: got %h want f628", vec[1][47:32]);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_reset_mid_payload();
    test_en_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
